// File: rtl/branch_resolve_stage.sv
// EX->MEM branch-resolution stage: computes pc_plus4 + offset_sl2, registers the
// taken decision, drives the PC-select mux and holds the wrong-path flush.
module branch_resolve_stage #(
  parameter int unsigned FLUSH_CYCLES = 1,
  parameter int unsigned CNT_W        = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic             stall,
  input  logic [31:0]      pc_plus4,
  input  logic [31:0]      offset_sl2,
  input  logic             is_branch,
  input  logic             branch_ne,
  input  logic             alu_zero,
  output logic             out_valid,
  output logic [31:0]      branch_target,
  output logic             pc_src,
  output logic             flush,
  output logic             align_err,
  output logic [CNT_W-1:0] taken_cnt
);

  typedef enum logic {RUN, FLUSH} state_t;

  localparam logic [2:0] CNT_INIT = 3'(FLUSH_CYCLES - 1);

  state_t      state;
  logic [2:0]  cnt;
  logic [31:0] target;
  logic        taken_in;

  // Carry is dropped, so backward offsets wrap modulo 2^32.
  assign target   = pc_plus4 + offset_sl2;
  // Anything arriving while flush is high is wrong-path and cannot redirect.
  assign taken_in = in_valid & is_branch & (alu_zero ^ branch_ne) & ~flush;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= RUN;
      cnt           <= 3'd0;
      out_valid     <= 1'b0;
      branch_target <= 32'd0;
      pc_src        <= 1'b0;
      flush         <= 1'b0;
      align_err     <= 1'b0;
      taken_cnt     <= '0;
    end else if (!stall) begin
      out_valid     <= in_valid & ~flush;
      branch_target <= target;
      if (taken_in) begin
        if (target[1:0] != 2'b00) align_err <= 1'b1;
        if (taken_cnt != {CNT_W{1'b1}}) taken_cnt <= taken_cnt + CNT_W'(1);
      end
      case (state)
        RUN: begin
          if (taken_in) begin
            pc_src <= 1'b1;
            flush  <= 1'b1;
            cnt    <= CNT_INIT;
            state  <= FLUSH;
          end else begin
            pc_src <= 1'b0;
            flush  <= 1'b0;
          end
        end
        FLUSH: begin
          pc_src <= 1'b0;
          if (cnt == 3'd0) begin
            flush <= 1'b0;
            state <= RUN;
          end else begin
            cnt <= cnt - 3'd1;
          end
        end
        default: state <= RUN;
      endcase
    end
  end

endmodule

// File: tb/tb_branch_resolve_stage.sv
// Directed bench for branch_resolve_stage: default instance plus a
// FLUSH_CYCLES=3 / CNT_W=2 instance for multi-cycle flush and saturation.
module tb_branch_resolve_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, stall, is_branch, branch_ne, alu_zero;
  logic [31:0] pc_plus4, offset_sl2;

  logic        out_valid, pc_src, flush, align_err;
  logic [31:0] branch_target;
  logic [15:0] taken_cnt;

  logic        out_valid2, pc_src2, flush2, align_err2;
  logic [31:0] branch_target2;
  logic [1:0]  taken_cnt2;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  branch_resolve_stage u_dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .stall(stall),
    .pc_plus4(pc_plus4), .offset_sl2(offset_sl2), .is_branch(is_branch),
    .branch_ne(branch_ne), .alu_zero(alu_zero), .out_valid(out_valid),
    .branch_target(branch_target), .pc_src(pc_src), .flush(flush),
    .align_err(align_err), .taken_cnt(taken_cnt)
  );

  branch_resolve_stage #(.FLUSH_CYCLES(3), .CNT_W(2)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .stall(stall),
    .pc_plus4(pc_plus4), .offset_sl2(offset_sl2), .is_branch(is_branch),
    .branch_ne(branch_ne), .alu_zero(alu_zero), .out_valid(out_valid2),
    .branch_target(branch_target2), .pc_src(pc_src2), .flush(flush2),
    .align_err(align_err2), .taken_cnt(taken_cnt2)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic br, input logic ne, input logic z,
                       input logic [31:0] pc, input logic [31:0] off);
    in_valid = v; is_branch = br; branch_ne = ne; alu_zero = z;
    pc_plus4 = pc; offset_sl2 = off;
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
  endtask

  task automatic test_reset();
    rst_n = 1'b0; stall = 1'b0; idle();
    tick(); tick();
    vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
    vectors++; if (branch_target !== 32'h0) begin miscompares++; $display("FAIL reset_target got %h want 0", branch_target); end
    vectors++; if (pc_src !== 1'b0) begin miscompares++; $display("FAIL reset_pc_src got %b want 0", pc_src); end
    vectors++; if (flush !== 1'b0) begin miscompares++; $display("FAIL reset_flush got %b want 0", flush); end
    vectors++; if (align_err !== 1'b0) begin miscompares++; $display("FAIL reset_align_err got %b want 0", align_err); end
    vectors++; if (taken_cnt !== 16'd0) begin miscompares++; $display("FAIL reset_taken_cnt got %0d want 0", taken_cnt); end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_beq_taken();
    drive(1'b1, 1'b1, 1'b0, 1'b1, 32'h0000_0104, 32'h0000_0010);
    tick();
    vectors++; if (branch_target !== 32'h0000_0114) begin miscompares++; $display("FAIL beq_target got %h want 00000114", branch_target); end
    vectors++; if (pc_src !== 1'b1) begin miscompares++; $display("FAIL beq_pc_src got %b want 1", pc_src); end
    vectors++; if (flush !== 1'b1) begin miscompares++; $display("FAIL beq_flush got %b want 1", flush); end
    vectors++; if (out_valid !== 1'b1) begin miscompares++; $display("FAIL beq_out_valid got %b want 1", out_valid); end
    vectors++; if (taken_cnt !== 16'd1) begin miscompares++; $display("FAIL beq_taken_cnt got %0d want 1", taken_cnt); end
    idle();
    tick();
    vectors++; if (pc_src !== 1'b0) begin miscompares++; $display("FAIL beq_pc_src_drop got %b want 0", pc_src); end
    vectors++; if (flush !== 1'b0) begin miscompares++; $display("FAIL beq_flush_drop got %b want 0", flush); end
    vectors++; if (align_err !== 1'b0) begin miscompares++; $display("FAIL beq_align_err got %b want 0", align_err); end
  endtask

  task automatic test_bne_not_taken();
    drive(1'b1, 1'b1, 1'b1, 1'b1, 32'h0000_0200, 32'h0000_0040);
    tick();
    vectors++; if (pc_src !== 1'b0) begin miscompares++; $display("FAIL bne_pc_src got %b want 0", pc_src); end
    vectors++; if (flush !== 1'b0) begin miscompares++; $display("FAIL bne_flush got %b want 0", flush); end
    vectors++; if (out_valid !== 1'b1) begin miscompares++; $display("FAIL bne_out_valid got %b want 1", out_valid); end
    vectors++; if (branch_target !== 32'h0000_0240) begin miscompares++; $display("FAIL bne_target got %h want 00000240", branch_target); end
    vectors++; if (taken_cnt !== 16'd1) begin miscompares++; $display("FAIL bne_taken_cnt got %0d want 1", taken_cnt); end
    idle();
    tick();
  endtask

  task automatic test_backward_wrap();
    drive(1'b1, 1'b1, 1'b0, 1'b1, 32'h0000_0008, 32'hFFFF_FFF8);
    tick();
    vectors++; if (branch_target !== 32'h0000_0000) begin miscompares++; $display("FAIL wrap_target got %h want 00000000", branch_target); end
    vectors++; if (pc_src !== 1'b1) begin miscompares++; $display("FAIL wrap_pc_src got %b want 1", pc_src); end
    vectors++; if (taken_cnt !== 16'd2) begin miscompares++; $display("FAIL wrap_taken_cnt got %0d want 2", taken_cnt); end
    idle();
    tick();
  endtask

  task automatic test_back_to_back();
    drive(1'b1, 1'b1, 1'b0, 1'b1, 32'h0000_1000, 32'h0000_0100);
    tick();
    vectors++; if (pc_src !== 1'b1) begin miscompares++; $display("FAIL b2b_first_pc_src got %b want 1", pc_src); end
    drive(1'b1, 1'b1, 1'b1, 1'b0, 32'h0000_2000, 32'h0000_0080);
    tick();
    vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL b2b_out_valid got %b want 0", out_valid); end
    vectors++; if (pc_src !== 1'b0) begin miscompares++; $display("FAIL b2b_pc_src got %b want 0", pc_src); end
    vectors++; if (flush !== 1'b0) begin miscompares++; $display("FAIL b2b_flush got %b want 0", flush); end
    vectors++; if (taken_cnt !== 16'd3) begin miscompares++; $display("FAIL b2b_taken_cnt got %0d want 3", taken_cnt); end
    idle();
    tick();
  endtask

  task automatic test_stall();
    drive(1'b1, 1'b1, 1'b0, 1'b1, 32'h0000_0300, 32'h0000_0020);
    tick();
    vectors++; if (pc_src !== 1'b1) begin miscompares++; $display("FAIL stall_entry_pc_src got %b want 1", pc_src); end
    stall = 1'b1;
    drive(1'b1, 1'b1, 1'b0, 1'b1, 32'h0000_0400, 32'h0000_0004);
    for (int i = 0; i < 3; i++) begin
      tick();
      vectors++; if (pc_src !== 1'b1) begin miscompares++; $display("FAIL stall_hold_pc_src[%0d] got %b want 1", i, pc_src); end
      vectors++; if (flush !== 1'b1) begin miscompares++; $display("FAIL stall_hold_flush[%0d] got %b want 1", i, flush); end
      vectors++; if (branch_target !== 32'h0000_0320) begin miscompares++; $display("FAIL stall_hold_target[%0d] got %h want 00000320", i, branch_target); end
    end
    stall = 1'b0;
    idle();
    tick();
    vectors++; if (pc_src !== 1'b0) begin miscompares++; $display("FAIL stall_release_pc_src got %b want 0", pc_src); end
    vectors++; if (flush !== 1'b0) begin miscompares++; $display("FAIL stall_release_flush got %b want 0", flush); end
    vectors++; if (taken_cnt !== 16'd4) begin miscompares++; $display("FAIL stall_taken_cnt got %0d want 4", taken_cnt); end
  endtask

  task automatic test_reset_mid_flush();
    drive(1'b1, 1'b1, 1'b0, 1'b1, 32'h0000_0100, 32'h0000_0002);
    tick();
    vectors++; if (align_err !== 1'b1) begin miscompares++; $display("FAIL rst_mid_align_err_set got %b want 1", align_err); end
    vectors++; if (flush !== 1'b1) begin miscompares++; $display("FAIL rst_mid_flush_set got %b want 1", flush); end
    #2;
    rst_n = 1'b0;
    #1;
    vectors++; if (pc_src !== 1'b0) begin miscompares++; $display("FAIL rst_mid_pc_src got %b want 0", pc_src); end
    vectors++; if (flush !== 1'b0) begin miscompares++; $display("FAIL rst_mid_flush got %b want 0", flush); end
    vectors++; if (branch_target !== 32'h0) begin miscompares++; $display("FAIL rst_mid_target got %h want 0", branch_target); end
    vectors++; if (align_err !== 1'b0) begin miscompares++; $display("FAIL rst_mid_align_err got %b want 0", align_err); end
    vectors++; if (taken_cnt !== 16'd0) begin miscompares++; $display("FAIL rst_mid_taken_cnt got %0d want 0", taken_cnt); end
    idle();
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  // Second instance: flush lasts three cycles and the 2-bit counter saturates at 3.
  task automatic test_long_flush_saturate();
    for (int n = 0; n < 4; n++) begin
      drive(1'b1, 1'b1, 1'b0, 1'b1, 32'h0000_0040, 32'h0000_0010);
      tick();
      vectors++; if (pc_src2 !== 1'b1) begin miscompares++; $display("FAIL long_pc_src[%0d] got %b want 1", n, pc_src2); end
      vectors++; if (taken_cnt2 !== ((n < 3) ? 2'(n + 1) : 2'd3)) begin miscompares++; $display("FAIL long_taken_cnt[%0d] got %0d want %0d", n, taken_cnt2, (n < 3) ? n + 1 : 3); end
      for (int k = 0; k < 3; k++) begin
        tick();
        vectors++; if (pc_src2 !== 1'b0) begin miscompares++; $display("FAIL long_pc_src_low[%0d.%0d] got %b want 0", n, k, pc_src2); end
        vectors++; if (flush2 !== (k < 2)) begin miscompares++; $display("FAIL long_flush[%0d.%0d] got %b want %b", n, k, flush2, k < 2); end
        vectors++; if (out_valid2 !== 1'b0) begin miscompares++; $display("FAIL long_out_valid[%0d.%0d] got %b want 0", n, k, out_valid2); end
      end
    end
    idle();
    tick();
  endtask

  initial begin
    test_reset();
    test_beq_taken();
    test_bne_not_taken();
    test_backward_wrap();
    test_back_to_back();
    test_stall();
    test_reset_mid_flush();
    test_long_flush_saturate();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
